// File: rtl/id_ex_queue.sv
// id_ex_queue: DEPTH-entry elastic ID/EX queue.
// - Valid/ready handshake on both the decode side and the execute side.
// - Global rdy freeze and a synchronous flush for branch mispredict.
// - Load-use hazard check across every buffered entry.
// - An empty head presents as an all-zero NOP bubble.
module id_ex_queue #(
   parameter int DATA_W = 112,
   parameter int DEPTH  = 2,
   parameter int RD_W   = 5
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         rdy_i,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [DATA_W-1:0]            in_data_i,
   input  logic [RD_W-1:0]              in_rd_i,
   input  logic                         in_rd_en_i,
   input  logic                         in_isload_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [DATA_W-1:0]            out_data_o,
   output logic [RD_W-1:0]              out_rd_o,
   output logic                         out_rd_en_o,
   output logic                         out_isload_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   input  logic [RD_W-1:0]              q_rs1_i,
   input  logic [RD_W-1:0]              q_rs2_i,
   output logic                         load_hazard_o
);

   // Pointer width is kept at least 1 bit; for DEPTH=1 the wrap logic pins the pointers to 0.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DATA_W-1:0] data_q   [DEPTH];
   logic [RD_W-1:0]   rd_q     [DEPTH];
   logic [DEPTH-1:0]  rd_en_q;
   logic [DEPTH-1:0]  isload_q;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [PW-1:0]     wp_q, wp_d;
   logic [PW-1:0]     rp_q, rp_d;
   logic [CW-1:0]     count_q, count_d;

   logic push, pop, head_vld;

   // Handshake terms.
   // in_ready is gated by reset so that every output reads 0 while rst is held.
   always_comb begin
      in_ready_o  = ~rst_i & rdy_i & ~flush_i & (count_q < CNT_FULL);
      out_valid_o = rdy_i & (count_q != '0);
      push        = in_valid_i & in_ready_o;
      pop         = out_valid_o & out_ready_i;
   end

   // Next-state for pointers, count and valid bits.
   // Flush wins over push/pop; rdy=0 freezes everything, including flush.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      valid_d = valid_q;
      if (rdy_i) begin
         if (flush_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            valid_d = '0;
         end else begin
            if (push) begin
               valid_d[wp_q] = 1'b1;
               wp_d          = (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
            end
            if (pop) begin
               valid_d[rp_q] = 1'b0;
               rp_d          = (rp_q == PTR_LAST) ? '0 : rp_q + 1'b1;
            end
            if (push && !pop) begin
               count_d = count_q + 1'b1;
            end else if (pop && !push) begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload storage; its contents are don't-care until the matching valid bit is set.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_q[wp_q]   <= in_data_i;
         rd_q[wp_q]     <= in_rd_i;
         rd_en_q[wp_q]  <= in_rd_en_i;
         isload_q[wp_q] <= in_isload_i;
      end
   end

   // Head fields, forced to a NOP bubble when the head slot is empty.
   always_comb begin
      head_vld     = valid_q[rp_q];
      out_data_o   = head_vld ? data_q[rp_q]   : '0;
      out_rd_o     = head_vld ? rd_q[rp_q]     : '0;
      out_rd_en_o  = head_vld & rd_en_q[rp_q];
      out_isload_o = head_vld & isload_q[rp_q];
      count_o      = count_q;
   end

   // Load-use hazard across all buffered entries; x0 never hazards.
   always_comb begin
      load_hazard_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && isload_q[i] && rd_en_q[i] && (rd_q[i] != '0) &&
             ((rd_q[i] == q_rs1_i) || (rd_q[i] == q_rs2_i))) begin
            load_hazard_o = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_queue.sv
// Directed bench for id_ex_queue at DEPTH=2 with hand-computed expectations.
module tb_id_ex_queue;

   localparam int DATA_W = 112;
   localparam int DEPTH  = 2;
   localparam int RD_W   = 5;
   localparam int CW     = $clog2(DEPTH + 1);

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              rdy_i;
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [DATA_W-1:0] in_data_i;
   logic [RD_W-1:0]   in_rd_i;
   logic              in_rd_en_i;
   logic              in_isload_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic [RD_W-1:0]   out_rd_o;
   logic              out_rd_en_o;
   logic              out_isload_o;
   logic [CW-1:0]     count_o;
   logic [RD_W-1:0]   q_rs1_i;
   logic [RD_W-1:0]   q_rs2_i;
   logic              load_hazard_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   id_ex_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rdy_i         (rdy_i),
      .flush_i       (flush_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .in_data_i     (in_data_i),
      .in_rd_i       (in_rd_i),
      .in_rd_en_i    (in_rd_en_i),
      .in_isload_i   (in_isload_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_data_o    (out_data_o),
      .out_rd_o      (out_rd_o),
      .out_rd_en_o   (out_rd_en_o),
      .out_isload_o  (out_isload_o),
      .count_o       (count_o),
      .q_rs1_i       (q_rs1_i),
      .q_rs2_i       (q_rs2_i),
      .load_hazard_o (load_hazard_o)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change 2 time units after it, away from the edge.
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic idle_in();
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      flush_i     = 1'b0;
      in_isload_i = 1'b0;
      in_rd_en_i  = 1'b1;
      in_rd_i     = '0;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                       input logic rd_en, input logic ld);
      in_valid_i  = 1'b1;
      in_data_i   = d;
      in_rd_i     = rd;
      in_rd_en_i  = rd_en;
      in_isload_i = ld;
      tick();
      in_valid_i  = 1'b0;
      #1;
   endtask

   task automatic pop();
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      #1;
   endtask

   initial begin
      rst_i       = 1'b1;
      rdy_i       = 1'b1;
      in_data_i   = '0;
      q_rs1_i     = '0;
      q_rs2_i     = '0;
      idle_in();

      // Reset state while rst is held.
      #12;
      check("rst_count",    128'(count_o),       128'd0);
      check("rst_in_ready", 128'(in_ready_o),    128'd0);
      check("rst_out_vld",  128'(out_valid_o),   128'd0);
      check("rst_hazard",   128'(load_hazard_o), 128'd0);
      check("rst_out_data", 128'(out_data_o),    128'd0);
      rst_i = 1'b0;
      #1;
      check("rel_in_ready", 128'(in_ready_o), 128'd1);

      // First push.
      push(112'hA5, 5'd3, 1'b1, 1'b0);
      check("p1_out_vld",  128'(out_valid_o), 128'd1);
      check("p1_out_data", 128'(out_data_o),  128'hA5);
      check("p1_out_rd",   128'(out_rd_o),    128'd3);
      check("p1_count",    128'(count_o),     128'd1);
      pop();
      check("p1_pop_cnt",  128'(count_o),     128'd0);
      check("p1_pop_vld",  128'(out_valid_o), 128'd0);
      check("p1_pop_data", 128'(out_data_o),  128'd0);
      check("p1_pop_rden", 128'(out_rd_en_o), 128'd0);

      // Fill and wrap.
      push(112'h11, 5'd1, 1'b1, 1'b0);
      push(112'h22, 5'd2, 1'b1, 1'b0);
      check("fill_count", 128'(count_o),    128'd2);
      check("fill_ready", 128'(in_ready_o), 128'd0);
      check("fill_head",  128'(out_data_o), 128'h11);
      push(112'h33, 5'd3, 1'b1, 1'b0);
      check("refuse_cnt",  128'(count_o),    128'd2);
      check("refuse_head", 128'(out_data_o), 128'h11);
      pop();
      check("popA_cnt",   128'(count_o),    128'd1);
      check("popA_head",  128'(out_data_o), 128'h22);
      check("popA_ready", 128'(in_ready_o), 128'd1);
      push(112'h33, 5'd3, 1'b1, 1'b0);
      check("pushC_cnt",  128'(count_o),    128'd2);
      check("pushC_head", 128'(out_data_o), 128'h22);
      pop();
      check("popB_head",  128'(out_data_o), 128'h33);
      check("popB_cnt",   128'(count_o),    128'd1);
      pop();
      check("popC_cnt",   128'(count_o),     128'd0);
      check("popC_vld",   128'(out_valid_o), 128'd0);

      // Full queue with simultaneous pop: push still refused.
      push(112'h41, 5'd1, 1'b1, 1'b0);
      push(112'h42, 5'd2, 1'b1, 1'b0);
      in_valid_i  = 1'b1;
      in_data_i   = 112'h43;
      out_ready_i = 1'b1;
      tick();
      idle_in();
      #1;
      check("fullpp_cnt",  128'(count_o),    128'd1);
      check("fullpp_head", 128'(out_data_o), 128'h42);
      pop();

      // Flush with concurrent push.
      push(112'h44, 5'd4, 1'b1, 1'b0);
      push(112'h55, 5'd5, 1'b1, 1'b0);
      flush_i     = 1'b1;
      in_valid_i  = 1'b1;
      in_data_i   = 112'h66;
      #1;
      check("flush_in_ready", 128'(in_ready_o), 128'd0);
      tick();
      idle_in();
      #1;
      check("flush_cnt",  128'(count_o),     128'd0);
      check("flush_vld",  128'(out_valid_o), 128'd0);
      check("flush_data", 128'(out_data_o),  128'd0);
      push(112'h77, 5'd7, 1'b1, 1'b0);
      check("postfl_head", 128'(out_data_o), 128'h77);
      check("postfl_cnt",  128'(count_o),    128'd1);

      // Freeze: rdy=0 with everything asserted.
      rdy_i       = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 112'h88;
      out_ready_i = 1'b1;
      flush_i     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("frz_in_ready", 128'(in_ready_o),  128'd0);
         check("frz_out_vld",  128'(out_valid_o), 128'd0);
         tick();
         check("frz_cnt",      128'(count_o),     128'd1);
         check("frz_head",     128'(out_data_o),  128'h77);
      end
      rdy_i = 1'b1;
      idle_in();
      #1;
      check("thaw_vld", 128'(out_valid_o), 128'd1);
      pop();
      check("thaw_pop_cnt", 128'(count_o), 128'd0);

      // Load hazard.
      push(112'h1, 5'd5, 1'b1, 1'b1);
      push(112'h2, 5'd6, 1'b1, 1'b0);
      q_rs1_i = 5'd5; q_rs2_i = 5'd0; #1;
      check("hz_rs1_load", 128'(load_hazard_o), 128'd1);
      q_rs1_i = 5'd0; q_rs2_i = 5'd6; #1;
      check("hz_rs2_alu", 128'(load_hazard_o), 128'd0);
      q_rs1_i = 5'd0; q_rs2_i = 5'd5; #1;
      check("hz_rs2_load", 128'(load_hazard_o), 128'd1);
      rdy_i = 1'b0; #1;
      check("hz_frozen", 128'(load_hazard_o), 128'd1);
      rdy_i = 1'b1;
      pop();
      q_rs1_i = 5'd5; q_rs2_i = 5'd5; #1;
      check("hz_popped", 128'(load_hazard_o), 128'd0);
      pop();
      push(112'h3, 5'd0, 1'b1, 1'b1);
      push(112'h4, 5'd7, 1'b0, 1'b1);
      q_rs1_i = 5'd0; q_rs2_i = 5'd0; #1;
      check("hz_x0", 128'(load_hazard_o), 128'd0);
      q_rs1_i = 5'd7; #1;
      check("hz_no_rden", 128'(load_hazard_o), 128'd0);
      check("hz_isload_head", 128'(out_isload_o), 128'd1);
      pop();
      pop();
      q_rs1_i = 5'd0;
      check("hz_empty_cnt", 128'(count_o), 128'd0);

      // Streaming: one in, one out per cycle.
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      in_rd_en_i  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         in_data_i = DATA_W'(100 + i);
         #1;
         if (i > 0) begin
            check("str_vld",  128'(out_valid_o), 128'd1);
            check("str_cnt",  128'(count_o),     128'd1);
            check("str_data", 128'(out_data_o),  128'(99 + i));
         end
         tick();
      end
      idle_in();
      #1;
      check("str_tail_data", 128'(out_data_o), 128'd119);
      check("str_tail_cnt",  128'(count_o),    128'd1);
      pop();
      check("str_end_cnt", 128'(count_o), 128'd0);

      // Mid-operation asynchronous reset.
      push(112'h99, 5'd9, 1'b1, 1'b1);
      q_rs1_i = 5'd9;
      #1;
      check("mr_hz_before", 128'(load_hazard_o), 128'd1);
      rst_i = 1'b1;
      #1;
      check("mr_cnt",  128'(count_o),       128'd0);
      check("mr_vld",  128'(out_valid_o),   128'd0);
      check("mr_hz",   128'(load_hazard_o), 128'd0);
      check("mr_data", 128'(out_data_o),    128'd0);
      rst_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard timeout so the bench can never hang.
   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
